// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int          DIV_STEPS     = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; one quotient bit per cycle,
// holds the execute stage via busy and pulses done with a registered result.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  div_op_t         op_q;
  logic [4:0]      cnt;
  logic [XLEN-1:0] rem, dvd, dsr;
  logic            neg_q, neg_r;

  logic            sgn, neg_a, neg_b, b_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, q_fix, r_fix;
  logic [XLEN:0]   trial;

  always_comb begin
    sgn    = ~op[0];
    neg_a  = sgn & a[XLEN-1];
    neg_b  = sgn & b[XLEN-1];
    abs_a  = neg_a ? -a : a;
    abs_b  = neg_b ? -b : b;
    b_zero = (b == '0);
    ovf    = sgn && (a == INT_MIN) && (b == '1);
    if (op[1]) spec_res = b_zero ? a : '0;
    else       spec_res = b_zero ? DIV_BY_ZERO_Q : INT_MIN;
    // The full 32-bit remainder is shifted so divisors above 2^31 still work.
    trial  = {rem, dvd[XLEN-1]} - {1'b0, dsr};
    q_fix  = neg_q ? -dvd : dvd;
    r_fix  = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= DIV;
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            op_q  <= div_op_t'(op);
            dvd   <= abs_a;
            dsr   <= abs_b;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            if (b_zero || ovf) begin
              result <= spec_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (!trial[XLEN]) rem <= trial[XLEN-1:0];
          else              rem <= {rem[XLEN-2:0], dvd[XLEN-1]};
          dvd <= {dvd[XLEN-2:0], ~trial[XLEN]};
          if (cnt == 5'(DIV_STEPS - 1)) state <= FIX;
        end
        FIX: begin
          result <= (op_q inside {REM, REMU}) ? r_fix : q_fix;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
